// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction loader.
// Macro UART_LOADER_CHECKSUM_EN adds the trailing-checksum state.
package loader_pkg;

  localparam int HDR_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int INSTR_W        = 32;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_WORD   = 3'd2,
    ST_DONE   = 3'd3,
`ifdef UART_LOADER_CHECKSUM_EN
    ST_CHK    = 3'd5,
`endif
    ST_ERR    = 3'd4
  } state_e;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte gap counter: cleared by clr, counts while en, flags expiry
// once it has sat at TIMEOUT_CYCLES-1.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_instr_loader.sv
// Assembles a length-prefixed UART byte stream into 32-bit instruction writes.
// Optional macro UART_LOADER_CHECKSUM_EN expects a trailing XOR checksum byte.
module uart_instr_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 16384,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_frame_err,
  output logic              instr_no_op,
  output logic [31:0]       instr_pc,
  output logic [INSTR_W-1:0] instr_word,
  output logic              loading,
  output logic              done,
  output logic              error,
  output logic [HDR_W-1:0]  words_loaded
);

  state_e               state_q, state_d;
  logic [HDR_W-1:0]     len_q, len_d;
  logic [BIDX_W-1:0]    bidx_q, bidx_d;
  logic [INSTR_W-1:0]   asm_q, asm_d;
  logic [HDR_W-1:0]     words_q, words_d;
  logic                 pend_q, pend_d;
  logic                 no_op_q, no_op_d;
  logic [INSTR_W-1:0]   word_q, word_d;
  logic [31:0]          pc_q, pc_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]           xor_q, xor_d;
`endif

  logic                 active;
  logic                 byte_ok;
  logic                 expired;
  logic [HDR_W-1:0]     n_len;
  logic [HDR_W-1:0]     words_inc;

  // A byte flagged with a framing error is never consumed.
  assign byte_ok   = load_en && rx_valid && !rx_frame_err;
  assign n_len     = {len_q[HDR_W-1:8], rx_data};
  assign words_inc = words_q + HDR_W'(1);

  always_comb begin
    active = 1'b0;
    case (state_q)
      ST_LEN_LO, ST_WORD: active = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
      ST_CHK:             active = 1'b1;
`endif
      default:            active = 1'b0;
    endcase
  end

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!load_en || rx_valid || !active),
    .en     (active),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    words_d = words_q;
    pend_d  = 1'b0;
    no_op_d = 1'b1;
    word_d  = word_q;
    pc_d    = pc_q;
`ifdef UART_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif

    if (!load_en) begin
      state_d = ST_IDLE;
      bidx_d  = '0;
      words_d = '0;
      pc_d    = BASE_ADDR;
`ifdef UART_LOADER_CHECKSUM_EN
      xor_d   = '0;
`endif
    end else begin
      // Write pipeline runs independently of the state so an in-flight
      // word still lands when the FSM drops into ERR.
      no_op_d = !pend_q;
      if (pend_q) begin
        word_d = asm_q;
      end
      if (!no_op_q) begin
        pc_d = pc_q + 32'd4;
      end

      case (state_q)
        ST_IDLE: begin
          if (byte_ok) begin
            len_d   = {rx_data, len_q[7:0]};
            bidx_d  = '0;
            words_d = '0;
            state_d = ST_LEN_LO;
`ifdef UART_LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
          end
        end

        ST_LEN_LO: begin
          if (rx_frame_err) begin
            state_d = ST_ERR;
          end else if (byte_ok) begin
            len_d = n_len;
            if (n_len == '0) begin
`ifdef UART_LOADER_CHECKSUM_EN
              state_d = ST_CHK;
`else
              state_d = ST_DONE;
`endif
            end else if ({16'd0, n_len} > MAX_WORDS) begin
              state_d = ST_ERR;
            end else begin
              state_d = ST_WORD;
            end
          end else if (expired) begin
            state_d = ST_ERR;
          end
        end

        ST_WORD: begin
          if (rx_frame_err) begin
            state_d = ST_ERR;
          end else if (byte_ok && (words_q != len_q)) begin
            asm_d = {asm_q[INSTR_W-9:0], rx_data};
`ifdef UART_LOADER_CHECKSUM_EN
            xor_d = xor_q ^ rx_data;
`endif
            if (bidx_q == BIDX_W'(BYTES_PER_WORD - 1)) begin
              bidx_d  = '0;
              pend_d  = 1'b1;
              words_d = words_inc;
`ifdef UART_LOADER_CHECKSUM_EN
              if (words_inc == len_q) begin
                state_d = ST_CHK;
              end
`endif
            end else begin
              bidx_d = bidx_q + BIDX_W'(1);
            end
          end else if (words_q == len_q) begin
            // All words captured; finish once the last write cycle is out.
            if (!no_op_q) begin
              state_d = ST_DONE;
            end
          end else if (expired) begin
            state_d = ST_ERR;
          end
        end

`ifdef UART_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (rx_frame_err) begin
            state_d = ST_ERR;
          end else if (byte_ok) begin
            state_d = (rx_data == xor_q) ? ST_DONE : ST_ERR;
          end else if (expired) begin
            state_d = ST_ERR;
          end
        end
`endif

        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      words_q <= '0;
      pend_q  <= 1'b0;
      no_op_q <= 1'b1;
      word_q  <= '0;
      pc_q    <= BASE_ADDR;
`ifdef UART_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      words_q <= words_d;
      pend_q  <= pend_d;
      no_op_q <= no_op_d;
      word_q  <= word_d;
      pc_q    <= pc_d;
`ifdef UART_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign instr_no_op  = no_op_q || !load_en;
  assign instr_pc     = pc_q;
  assign instr_word   = word_q;
  assign loading      = active;
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Self-checking bench for uart_instr_loader: table vectors, corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_uart_instr_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 16384;
  localparam int unsigned TMO  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_en = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_frame_err = 1'b0;
  logic        instr_no_op;
  logic [31:0] instr_pc;
  logic [31:0] instr_word;
  logic        loading;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int nvec = 0;
  int nfail = 0;
  logic [63:0] wq[$];

  uart_instr_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_frame_err(rx_frame_err), .instr_no_op(instr_no_op),
    .instr_pc(instr_pc), .instr_word(instr_word), .loading(loading),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Every write cycle observed on the instruction port, as {pc, word}.
  always @(negedge clk) begin
    if (rst_n && !instr_no_op) wq.push_back({instr_pc, instr_word});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [15:0]      hdr;
    logic [7:0]       nw;
    logic [3:0][31:0] w;
    logic             e_done;
    logic             e_err;
    logic [7:0]       e_words;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic restart();
    load_en = 1'b0;
    rx_valid = 1'b0;
    rx_frame_err = 1'b0;
    tick();
    tick();
    load_en = 1'b1;
    wq.delete();
  endtask

  task automatic send_frame(input logic [15:0] hdr, input int nw,
                            input logic [3:0][31:0] w, input int maxgap);
    logic [7:0] xs;
    logic [7:0] b;
    xs = 8'h00;
    send_byte(hdr[15:8], $urandom_range(maxgap, 0));
    send_byte(hdr[7:0], $urandom_range(maxgap, 0));
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = w[k][31-8*j -: 8];
        xs = xs ^ b;
        send_byte(b, $urandom_range(maxgap, 0));
      end
    end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(xs, 0);
`endif
  endtask

  task automatic check_writes(input string tag, input int n, input logic [3:0][31:0] w);
    chk({tag, ".nwrites"}, 32'(wq.size()), 32'(n));
    for (int k = 0; k < n && k < wq.size(); k++) begin
      chk({tag, ".pc"}, wq[k][63:32], BASE + 32'(4 * k));
      chk({tag, ".word"}, wq[k][31:0], w[k]);
    end
  endtask

  function automatic vec_t mkvec(input logic [15:0] hdr, input int nw,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2, input logic d, input logic e,
                                 input int nwr);
    vec_t v;
    v.hdr = hdr;
    v.nw = 8'(nw);
    v.w = {32'h0, w2, w1, w0};
    v.e_done = d;
    v.e_err = e;
    v.e_words = 8'(nwr);
    return v;
  endfunction

  initial begin
    logic [3:0][31:0] w;
    logic [15:0] hdr;
    int nw;
    int exp_n;
    logic exp_err;

    tbl[0] = mkvec(16'h0002, 2, 32'h8C02_0000, 32'h2008_0004, 32'h0, 1'b1, 1'b0, 2);
    tbl[1] = mkvec(16'h0000, 0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 0);
    tbl[2] = mkvec(16'h4001, 1, 32'h1122_3344, 32'h0, 32'h0, 1'b0, 1'b1, 0);
    tbl[3] = mkvec(16'h0003, 3, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 3);
    tbl[4] = mkvec(16'h0001, 1, 32'hA5A5_5A5A, 32'h0, 32'h0, 1'b1, 1'b0, 1);

    repeat (3) tick();
    chk("rst.no_op", 32'(instr_no_op), 32'd1);
    chk("rst.pc", instr_pc, BASE);
    chk("rst.word", instr_word, 32'h0);
    chk("rst.loading", 32'(loading), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    chk("rst.words", 32'(words_loaded), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table vectors, bytes sent back-to-back.
    for (int i = 0; i < 5; i++) begin
      restart();
      send_frame(tbl[i].hdr, int'(tbl[i].nw), tbl[i].w, 0);
      repeat (4) tick();
      check_writes($sformatf("tbl%0d", i), int'(tbl[i].e_words), tbl[i].w);
      chk($sformatf("tbl%0d.done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d.error", i), 32'(error), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d.words", i), 32'(words_loaded), 32'(tbl[i].e_words));
      chk($sformatf("tbl%0d.loading", i), 32'(loading), 32'd0);
    end

    // Write latency and address advance around the 4th byte.
    restart();
    send_byte(8'h00, 0);
    chk("lat.loading", 32'(loading), 32'd1);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    chk("lat.no_op_t", 32'(instr_no_op), 32'd1);
    tick();
    chk("lat.no_op_t1", 32'(instr_no_op), 32'd0);
    chk("lat.pc_t1", instr_pc, BASE);
    chk("lat.word_t1", instr_word, 32'h1234_5678);
    tick();
    chk("lat.no_op_t2", 32'(instr_no_op), 32'd1);
    chk("lat.pc_t2", instr_pc, BASE + 32'd4);
    chk("lat.word_hold", instr_word, 32'h1234_5678);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'h08, 0);
`endif
    chk("lat.done", 32'(done), 32'd1);
    chk("lat.loading_off", 32'(loading), 32'd0);

    // DONE is sticky: a further frame produces nothing.
    wq.delete();
    send_frame(16'h0001, 1, {96'h0, 32'hCAFE_F00D}, 0);
    repeat (3) tick();
    chk("sticky.nwrites", 32'(wq.size()), 32'd0);
    chk("sticky.done", 32'(done), 32'd1);
    chk("sticky.words", 32'(words_loaded), 32'd1);

    // Timeout after two payload bytes.
    restart();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    repeat (15) tick();
    chk("tmo.before", 32'(error), 32'd0);
    tick();
    chk("tmo.error", 32'(error), 32'd1);
    chk("tmo.nwrites", 32'(wq.size()), 32'd0);

    // Framing error coincident with the 4th byte: byte dropped, no write.
    restart();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    rx_frame_err = 1'b1;
    send_byte(8'hDD, 0);
    rx_frame_err = 1'b0;
    repeat (3) tick();
    chk("ferr.error", 32'(error), 32'd1);
    chk("ferr.nwrites", 32'(wq.size()), 32'd0);
    chk("ferr.words", 32'(words_loaded), 32'd0);

    // Framing error right after a completed word: the write still lands.
    restart();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    rx_frame_err = 1'b1;
    tick();
    rx_frame_err = 1'b0;
    repeat (3) tick();
    chk("inflt.error", 32'(error), 32'd1);
    chk("inflt.done", 32'(done), 32'd0);
    check_writes("inflt", 1, {96'h0, 32'h1122_3344});

    // Abort mid-frame then reload from scratch.
    restart();
    send_frame(16'h0002, 0, '0, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    tick();
    load_en = 1'b0;
    tick();
    chk("abort.loading", 32'(loading), 32'd0);
    chk("abort.words", 32'(words_loaded), 32'd0);
    chk("abort.pre_nwrites", 32'(wq.size()), 32'd1);
    load_en = 1'b1;
    wq.delete();
    send_frame(16'h0001, 1, {96'h0, 32'hAD02_0000}, 0);
    repeat (4) tick();
    check_writes("reload", 1, {96'h0, 32'hAD02_0000});
    chk("reload.done", 32'(done), 32'd1);

`ifdef UART_LOADER_CHECKSUM_EN
    restart();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    repeat (3) tick();
    chk("cks_ok.done", 32'(done), 32'd1);
    restart();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h09, 0);
    repeat (3) tick();
    chk("cks_bad.error", 32'(error), 32'd1);
    check_writes("cks_bad", 1, {96'h0, 32'h0800_0000});
`endif

    // Random frames with random inter-byte gaps, checked against a
    // frame-level model: oversize headers write nothing, others write all N.
    for (int r = 0; r < 20; r++) begin
      nw = $urandom_range(4, 1);
      for (int k = 0; k < 4; k++) w[k] = $urandom();
      if ($urandom_range(4, 0) == 0) begin
        hdr = 16'(MAXW + 1 + $urandom_range(200, 0));
        exp_err = 1'b1;
        exp_n = 0;
      end else begin
        hdr = 16'(nw);
        exp_err = 1'b0;
        exp_n = nw;
      end
      restart();
      send_frame(hdr, nw, w, 3);
      repeat (4) tick();
      check_writes($sformatf("rnd%0d", r), exp_n, w);
      chk($sformatf("rnd%0d.error", r), 32'(error), 32'(exp_err));
      chk($sformatf("rnd%0d.done", r), 32'(done), 32'(!exp_err));
      chk($sformatf("rnd%0d.words", r), 32'(words_loaded), 32'(exp_n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/uart_instr_loader.md
# uart_instr_loader

Upstream feeder for the instruction-memory write port of `top_modified`. Assembles a framed byte stream from the UART receiver into 32-bit instructions. Drives `instruction_mem_no_op_input`, `instruction_mem_pc_input` and `instruction_mem_instruction_input` with one write per assembled word, at sequential word addresses. It also reports progress, completion and error status to the top level: `uart_in_progress`, LEDs and seven-segment display.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word.
- `MAX_WORDS`, 16384: largest accepted word count; larger headers are errors.
- `TIMEOUT_CYCLES`, 1_000_000: maximum idle gap between bytes inside a frame.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load_en`  in  1  level; loader active while high; low forces IDLE from any state.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `rx_data`  in  8  received byte.
- `rx_frame_err`  in  1  one-cycle strobe, UART framing error.
- `instr_no_op`  out  1  low = write `instr_word` at `instr_pc` this cycle.
- `instr_pc`  out  32  write byte address.
- `instr_word`  out  32  write data.
- `loading`  out  1  high from first header byte until DONE/ERR.
- `done`  out  1  level, frame loaded successfully.
- `error`  out  1  level, frame aborted.
- `words_loaded`  out  16  count of words written in current frame.

## Operation
- Frame format, big-endian: `N[15:8]`, `N[7:0]`, then N words of 4 bytes each, MSB byte first. With the configuration macro, a checksum byte follows the words.
- States:
  - IDLE: on `rx_valid`, go to LEN_LO.
  - LEN_LO: on `rx_valid`, go to WORD.
  - WORD: byte index 0..3.
  - CHK: only present with the configuration macro.
  - DONE.
  - ERR.
- IDLE: header byte 0 is captured into N[15:8].
- LEN_LO: byte 1 is captured into N[7:0].
  - N == 0: go to DONE, or CHK with the macro.
  - N > MAX_WORDS: go to ERR.
  - Otherwise: go to WORD.
- WORD: each byte shifts into the assembly register.
  - On byte index 3: issue a write, increment `words_loaded`, reset the byte index.
  - After the N-th word: go to DONE, or to CHK with the macro.
- Address of word k (0-based) is BASE_ADDR + 4·k. Address arithmetic is 32-bit and wraps modulo 2^32; no error on wrap.
- DONE/ERR: sticky. Further `rx_valid` is ignored. Exit only via `load_en` low or reset.
- `rx_frame_err` in any active state (IDLE excluded) goes to ERR. In IDLE it is ignored.
- Timeout: a gap counter is cleared on each `rx_valid`. It runs in LEN_LO/WORD/CHK. When it reaches TIMEOUT_CYCLES−1 without a byte, go to ERR.
- Partial word at abort is discarded; no write is issued.
- `load_en` low: go to IDLE next cycle and clear `done`, `error`, `loading`, `words_loaded` and the byte index. `instr_no_op` is forced high.
- `rx_valid` while `load_en` is low is ignored.

## Timing
- Reset values:
  - `instr_no_op`=1.
  - `instr_pc`=BASE_ADDR.
  - `instr_word`=0.
  - `loading`=0, `done`=0, `error`=0.
  - `words_loaded`=0.
  - State IDLE.
- Write latency: the 4th byte of a word is accepted at edge t. `instr_no_op`=0 during cycle t+1 only, with `instr_pc`/`instr_word` valid in that cycle.
- Address update: `instr_pc` advances by 4 at edge t+2 and holds otherwise. `instr_word` holds its last value.
- `done` rises at the edge after the last word's write cycle, or after the checksum byte with the macro. `loading` falls at the same edge.
- `error` rises at the edge where the error condition is detected. A write in flight that cycle still completes.
- `rx_valid` and `rx_frame_err` in the same cycle: the error wins and the byte is dropped.
- Back-to-back `rx_valid` on consecutive cycles is supported with no throughput loss.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined: a trailing byte equal to the XOR of all 4N payload bytes is expected in CHK.
  - Match: go to DONE.
  - Mismatch: go to ERR.
  - Timeout applies in CHK.
- Undefined: CHK and the XOR accumulator are absent, and the last word goes directly to DONE.

## Structure
- Shared package `loader_pkg`:
  - State enum type.
  - Header width constant (16).
  - Bytes-per-word constant (4).
  - Instruction width constant (32).
- Sub-module `loader_timeout`: gap counter with clear/enable inputs and an `expired` output, parameterised by TIMEOUT_CYCLES.

## Test plan
- Basic load: `load_en`=1, bytes 00 02 8C 02 00 00 20 08 00 04 -> two writes, then DONE.
  - Write 1: pc 0x0, word 0x8C020000. Write 2: pc 0x4, word 0x20080004.
  - `done`=1, `words_loaded`=2.
- Zero length: header 00 00 -> no writes; `done`=1 next cycle (macro off).
- Oversize header: header 40 01, MAX_WORDS=16384 -> `error`=1; later bytes produce no writes.
- Timeout: TIMEOUT_CYCLES=16; header 00 01, two payload bytes, then silence -> `error` at the 16th idle cycle; no write.
- Abort and restart: drop `load_en` mid-word, then raise it again.
  - `loading`=0 and `words_loaded`=0.
  - A new frame 00 01 AD 02 00 00 writes 0xAD020000 at pc 0x0.
- Checksum (macro on): payload 08 00 00 00 with checksum 08 -> DONE. Same payload with checksum 09 -> ERR, and the word is still written.
